alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle command sequencer that drives the 8-bit combinational ALU from the initiator side.
- Accepts 8- or 16-bit commands over a valid/ready handshake and issues one or more 8-bit ALU passes.
- Chains carry/borrow between bytes and computes Z/N itself from the assembled result.
- Returns the result and flags over a second valid/ready handshake.
- Sits between the core's execute stage and the ALU; one command outstanding at a time.

## Interface
- No parameters. Op encoding is fixed: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT; 8–15 are illegal.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  operation code
- cmd_wide  in  1  1 = 16-bit operation, 0 = 8-bit (uses [7:0] only)
- cmd_a  in  16  operand A
- cmd_b  in  16  operand B (ignored for INC/DEC/NOT)
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_op  out  4  ALU op code
- alu_out  in  8  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_c  in  1  ALU carry (ADD/INC) or borrow (SUB/DEC)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  16  result; [15:8] = 0 for narrow commands
- rsp_z, rsp_c, rsp_n, rsp_err  out  1 each  zero, carry/borrow, negative, illegal-op flags

## Operation
- States: IDLE, LO, HI, FIX, RESP.
- Command capture:
  - cmd_ready = (state == IDLE).
  - On cmd_valid && cmd_ready: register op, wide, a, b.
  - Illegal op → RESP with rsp_err=1, rsp_data=0, all other flags 0, no ALU pass.
  - Legal op → LO.
- LO: drive a[7:0], b[7:0] with the op. Capture lo = alu_out and c0 = alu_c.
  - Narrow → RESP.
  - Wide → HI.
- HI: drive a[15:8] and capture hi = alu_out, c1 = alu_c. The ALU inputs depend on the op:
  - ADD/SUB: b[15:8] with the same op.
  - INC: op ADD, b = {7'b0, c0}.
  - DEC: op SUB, b = {7'b0, c0}.
  - Logic ops: b[15:8] with the same op.
  - NOT: a[15:8] with op NOT.
  - Next state: FIX if (ADD or SUB) and c0=1; otherwise RESP.
- FIX: drive hi with op INC (for ADD) or DEC (for SUB). Capture hi = alu_out, c2 = alu_c → RESP.
- Carry/borrow rules:
  - ALU carry/borrow is trusted.
  - Narrow: C = c0 for ADD/SUB/INC/DEC.
  - Wide: C = c1 | c2 (c2 = 0 if FIX is skipped).
  - Logic ops: C = 0.
- Zero/negative rules: ALU Z/N are not used; the sequencer computes them.
  - Z = (result over the active width == 0).
  - N = msb of the active width (bit 7 narrow, bit 15 wide).
- RESP: rsp_valid=1 and all rsp_* held stable until rsp_ready. On handshake → IDLE.
- In IDLE and RESP, alu_a, alu_b and alu_op are driven to 0.

## Timing
- Reset values (asynchronous assertion, effective immediately):
  - state = IDLE.
  - cmd_ready = 1 once reset deasserts.
  - rsp_valid=0, rsp_data=0, rsp_z/c/n/err=0.
  - alu_a=0, alu_b=0, alu_op=0.
- Latency, with the command accepted at edge T:
  - illegal: rsp_valid rises after edge T+1.
  - narrow: after edge T+2.
  - wide without FIX: after edge T+3.
  - wide with FIX: after edge T+4.
- ALU capture: each of LO/HI/FIX lasts exactly one cycle; alu_out/alu_c are sampled at the edge leaving the state.
- Back-to-back commands: no same-cycle re-accept. cmd_ready returns the cycle after the response handshake.
- Backpressure: rsp_ready low holds RESP indefinitely with outputs unchanged; cmd_ready stays 0.
- Reset mid-command (any state): the command is abandoned and no response is produced. After reset deasserts, state is IDLE and the next accepted command behaves normally.
- cmd_* inputs are ignored whenever cmd_ready = 0.

## Test plan
- Narrow ADD: a=0xFF, b=0x01 → rsp_data=0x0000, Z=1, C=1, N=0; rsp_valid after edge T+2.
- Wide ADD:
  - 0x00FF+0x0001 → 0x0100, Z=0, C=0; FIX visited, response after T+4.
  - 0xFFFF+0x0001 → 0x0000, Z=1, C=1.
- Wide SUB:
  - 0x0000−0x0001 → 0xFFFF, C=1, N=1.
  - 0x0100−0x0001 → 0x00FF, C=0, N=0.
- Wide INC 0x00FF → 0x0100, C=0. Wide DEC 0x0000 → 0xFFFF, C=1; no FIX, response after T+3.
- Narrow NOT 0x0F → 0xF0, N=1, C=0. Illegal op 0xA → rsp_err=1, data=0, response after T+1, alu_op stays 0.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles → outputs stable and cmd_ready=0.
  - Assert rst during HI → rsp_valid=0 and cmd_ready=1 after release.
  - A subsequent narrow XOR 0xAA^0x55 → 0xFF, N=1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequences 8/16-bit commands over an external 8-bit ALU; response 1/2/3/4 cycles after accept (illegal/narrow/wide/wide+fix).
// One command outstanding; cmd_ready only in IDLE, response held until rsp_ready.
module alu_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic        cmd_wide,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_op,
   input  logic [7:0]  alu_out,
   input  logic        alu_c,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_z,
   output logic        rsp_c,
   output logic        rsp_n,
   output logic        rsp_err
);

   typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_INC = 4'd2;
   localparam logic [3:0] OP_DEC = 4'd3;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic        wide_q, wide_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;
   logic        c0_q, c0_d;
   logic        c1_q, c1_d;
   logic        c2_q, c2_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_z_q, rsp_z_d;
   logic        rsp_c_q, rsp_c_d;
   logic        rsp_n_q, rsp_n_d;
   logic        rsp_err_q, rsp_err_d;

   logic [15:0] result;
   logic        is_arith;
   logic        is_illegal;
   logic        carry;

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_n     = rsp_n_q;
   assign rsp_err   = rsp_err_q;

   // Narrow results ignore hi_q, which may hold a stale byte from an earlier command.
   assign result     = wide_q ? {hi_q, lo_q} : {8'h00, lo_q};
   assign is_arith   = (op_q[3:2] == 2'b00);
   assign is_illegal = op_q[3];
   assign carry      = !is_arith ? 1'b0 : (wide_q ? (c1_q | c2_q) : c0_q);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      wide_d      = wide_q;
      a_d         = a_q;
      b_d         = b_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      c0_d        = c0_q;
      c1_d        = c1_q;
      c2_d        = c2_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_z_d     = rsp_z_q;
      rsp_c_d     = rsp_c_q;
      rsp_n_d     = rsp_n_q;
      rsp_err_d   = rsp_err_q;
      alu_a       = 8'h00;
      alu_b       = 8'h00;
      alu_op      = 4'h0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               wide_d  = cmd_wide;
               a_d     = cmd_a;
               b_d     = cmd_b;
               c1_d    = 1'b0;
               c2_d    = 1'b0;
               state_d = cmd_op[3] ? RESP : LO;
            end
         end
         LO: begin
            alu_a   = a_q[7:0];
            alu_b   = b_q[7:0];
            alu_op  = op_q;
            lo_d    = alu_out;
            c0_d    = alu_c;
            state_d = wide_q ? HI : RESP;
         end
         HI: begin
            alu_a = a_q[15:8];
            // INC/DEC propagate the low-byte carry/borrow as an ADD/SUB of c0.
            case (op_q)
               OP_INC: begin
                  alu_op = OP_ADD;
                  alu_b  = {7'b0, c0_q};
               end
               OP_DEC: begin
                  alu_op = OP_SUB;
                  alu_b  = {7'b0, c0_q};
               end
               default: begin
                  alu_op = op_q;
                  alu_b  = b_q[15:8];
               end
            endcase
            hi_d    = alu_out;
            c1_d    = alu_c;
            state_d = (((op_q == OP_ADD) || (op_q == OP_SUB)) && c0_q) ? FIX : RESP;
         end
         FIX: begin
            alu_a   = hi_q;
            alu_op  = (op_q == OP_ADD) ? OP_INC : OP_DEC;
            hi_d    = alu_out;
            c2_d    = alu_c;
            state_d = RESP;
         end
         RESP: begin
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = is_illegal;
               rsp_data_d  = is_illegal ? 16'h0000 : result;
               rsp_c_d     = is_illegal ? 1'b0 : carry;
               rsp_z_d     = is_illegal ? 1'b0 : (result == 16'h0000);
               rsp_n_d     = is_illegal ? 1'b0 : (wide_q ? result[15] : result[7]);
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_data_d  = 16'h0000;
               rsp_z_d     = 1'b0;
               rsp_c_d     = 1'b0;
               rsp_n_d     = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= 4'h0;
         wide_q      <= 1'b0;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         lo_q        <= 8'h00;
         hi_q        <= 8'h00;
         c0_q        <= 1'b0;
         c1_q        <= 1'b0;
         c2_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 16'h0000;
         rsp_z_q     <= 1'b0;
         rsp_c_q     <= 1'b0;
         rsp_n_q     <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         wide_q      <= wide_d;
         a_q         <= a_d;
         b_q         <= b_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         c0_q        <= c0_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_z_q     <= rsp_z_d;
         rsp_c_q     <= rsp_c_d;
         rsp_n_q     <= rsp_n_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 8-bit ALU on the initiator side.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = 4'h0;
   logic        cmd_wide = 1'b0;
   logic [15:0] cmd_a = 16'h0;
   logic [15:0] cmd_b = 16'h0;
   logic [7:0]  alu_a, alu_b, alu_out;
   logic [3:0]  alu_op;
   logic        alu_c;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic        rsp_z, rsp_c, rsp_n, rsp_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wide(cmd_wide),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_n(rsp_n), .rsp_err(rsp_err)
   );

   // Reference ALU: carry for ADD/INC, borrow for SUB/DEC, 0 for logic ops.
   always_comb begin
      logic [8:0] t;
      t = 9'h000;
      case (alu_op)
         4'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
         4'd1: t = {1'b0, alu_a} - {1'b0, alu_b};
         4'd2: t = {1'b0, alu_a} + 9'd1;
         4'd3: t = {1'b0, alu_a} - 9'd1;
         4'd4: t = {1'b0, alu_a & alu_b};
         4'd5: t = {1'b0, alu_a | alu_b};
         4'd6: t = {1'b0, alu_a ^ alu_b};
         4'd7: t = {1'b0, ~alu_a};
         default: t = 9'h000;
      endcase
      alu_out = t[7:0];
      alu_c   = t[8];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_cmd(input string tag, input logic [3:0] op, input logic wide,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e_data, input logic e_z, input logic e_c,
                          input logic e_n, input logic e_err, input int e_lat, input int bp);
      int  lat;
      logic alu_op_quiet;
      logic [19:0] snap;
      @(negedge clk);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_wide = wide; cmd_a = a; cmd_b = b;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      cmd_a = 16'hDEAD; cmd_b = 16'hBEEF; cmd_op = 4'h5;
      lat = 0;
      alu_op_quiet = 1'b1;
      while (lat <= 20) begin
         if (alu_op !== 4'h0) alu_op_quiet = 1'b0;
         @(posedge clk);
         lat++;
         #1;
         if (rsp_valid) break;
      end
      chk({tag, "_latency"}, lat, e_lat);
      if (e_err) chk({tag, "_alu_op_idle"}, alu_op_quiet, 1'b1);
      chk({tag, "_data"}, rsp_data, e_data);
      chk({tag, "_flags_zcne"}, {rsp_z, rsp_c, rsp_n, rsp_err}, {e_z, e_c, e_n, e_err});
      snap = {rsp_data, rsp_z, rsp_c, rsp_n, rsp_err};
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk({tag, "_bp_hold"}, {rsp_valid, cmd_ready, rsp_data, rsp_z, rsp_c, rsp_n, rsp_err},
             {2'b10, snap});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk({tag, "_post_hs"}, {rsp_valid, cmd_ready}, 2'b01);
   endtask

   initial begin
      #2;
      chk("rst_outputs", {rsp_valid, rsp_data, rsp_z, rsp_c, rsp_n, rsp_err},
          {1'b0, 16'h0, 4'h0});
      chk("rst_alu", {alu_a, alu_b, alu_op}, 20'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);

      //      tag          op    w     a        b        data     z     c     n     err  lat bp
      run_cmd("n_add",    4'd0, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0);
      run_cmd("w_add_fix",4'd0, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0);
      run_cmd("w_add_ovf",4'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0);
      run_cmd("w_sub_neg",4'd1, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0);
      run_cmd("w_sub",    4'd1, 1'b1, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0);
      run_cmd("w_inc",    4'd2, 1'b1, 16'h00FF, 16'h5555, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
      run_cmd("w_dec",    4'd3, 1'b1, 16'h0000, 16'h5555, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0);
      run_cmd("n_not",    4'd7, 1'b0, 16'hAB0F, 16'h1234, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0);
      run_cmd("illegal",  4'hA, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
      run_cmd("w_and_bp", 4'd4, 1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 3, 5);

      // Abort a wide ADD while it is in HI.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'd0; cmd_wide = 1'b1; cmd_a = 16'h1234; cmd_b = 16'h0101;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("hi_alu_drive", {alu_a, alu_b, alu_op}, {8'h12, 8'h01, 4'd0});
      rst = 1'b1;
      #1;
      chk("midrst_alu", {alu_a, alu_b, alu_op}, 20'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst_idle", {rsp_valid, cmd_ready}, 2'b01);
      end

      run_cmd("n_xor",    4'd6, 1'b0, 16'h12AA, 16'h3455, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
